// File: rtl/elastic_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module  : elastic_pipeline_reg
// Brief   : Inter-stage pipeline register with valid/ready handshake, optional
//           2-entry skid buffer, stage-local flush and global BUSYWAIT freeze.
// Revision: 1.0 - initial release
// ============================================================================
module elastic_pipeline_reg #(
  parameter int DATA_WIDTH  = 136,
  parameter bit SKID_ENABLE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  input  logic                  FLUSH,
  input  logic                  BUSYWAIT,
  output logic [1:0]            OCCUPANCY
);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic                  w_main_valid;
  logic                  w_skid_valid;
  logic                  w_acc;
  logic                  w_iss;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_main_from_skid;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_skid_valid = (r_state == ST_TWO);

  generate
    if (SKID_ENABLE) begin : g_skid_ready
      // Ready comes from a flop only, breaking the OUT_READY -> IN_READY path.
      assign IN_READY = !w_skid_valid && !BUSYWAIT && !RESET;
    end else begin : g_comb_ready
      assign IN_READY = (!w_main_valid || OUT_READY) && !BUSYWAIT && !RESET;
    end
  endgenerate

  assign w_acc     = IN_VALID && IN_READY;
  assign w_iss     = w_main_valid && OUT_READY && !BUSYWAIT;
  assign OUT_VALID = w_main_valid;
  assign OUT_DATA  = r_main_data;
  assign OCCUPANCY = {w_skid_valid, w_main_valid && !w_skid_valid};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (FLUSH) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_iss) begin
            w_load_main = 1'b1;
          end else if (w_acc) begin
            // Only reachable with the skid; without it accept implies issue.
            if (SKID_ENABLE) begin
              w_state_nxt = ST_TWO;
              w_load_skid = 1'b1;
            end
          end else if (w_iss) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_iss) begin
            w_state_nxt      = ST_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_main_data <= '0;
    end else if (w_load_main) begin
      r_main_data <= IN_DATA;
    end else if (w_main_from_skid) begin
      r_main_data <= w_skid_data;
    end
  end

  generate
    if (SKID_ENABLE) begin : g_skid_buf
      logic [DATA_WIDTH-1:0] r_skid_data;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_skid_data <= '0;
        end else if (w_load_skid) begin
          r_skid_data <= IN_DATA;
        end
      end

      assign w_skid_data = r_skid_data;
    end else begin : g_no_skid
      assign w_skid_data = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_elastic_pipeline_reg
// Brief   : Drives a skid build and a no-skid build side by side against a
//           queue model of the handshake rules; directed steps then random.
// Revision: 1.0 - initial release
// ============================================================================
module tb_elastic_pipeline_reg;
  localparam int DW = 136;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IN_VALID;
  logic [DW-1:0] IN_DATA;
  logic          OUT_READY;
  logic          FLUSH;
  logic          BUSYWAIT;

  logic          rdy1, vld1, rdy0, vld0;
  logic [DW-1:0] dat1, dat0;
  logic [1:0]    occ1, occ0;

  int n_vec = 0;
  int n_bad = 0;

  // Model: per build (index 1 = skid, 0 = no skid), an ordered list of held payloads.
  logic [DW-1:0] mq [2][4];
  int            mcnt [2];

  always #5 CLK = ~CLK;

  elastic_pipeline_reg #(.DATA_WIDTH(DW), .SKID_ENABLE(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy1), .IN_DATA(IN_DATA),
    .OUT_VALID(vld1), .OUT_READY(OUT_READY), .OUT_DATA(dat1), .FLUSH(FLUSH),
    .BUSYWAIT(BUSYWAIT), .OCCUPANCY(occ1)
  );

  elastic_pipeline_reg #(.DATA_WIDTH(DW), .SKID_ENABLE(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy0), .IN_DATA(IN_DATA),
    .OUT_VALID(vld0), .OUT_READY(OUT_READY), .OUT_DATA(dat0), .FLUSH(FLUSH),
    .BUSYWAIT(BUSYWAIT), .OCCUPANCY(occ0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int m);
    if (RESET || BUSYWAIT) return 1'b0;
    if (m == 1) return (mcnt[1] < 2);
    return (mcnt[0] == 0) || OUT_READY;
  endfunction

  task automatic model_check(input int m);
    logic          o_rdy, o_vld;
    logic [1:0]    o_occ;
    logic [DW-1:0] o_dat;
    o_rdy = (m == 1) ? rdy1 : rdy0;
    o_vld = (m == 1) ? vld1 : vld0;
    o_occ = (m == 1) ? occ1 : occ0;
    o_dat = (m == 1) ? dat1 : dat0;
    chk($sformatf("in_ready[b%0d]", m), DW'(o_rdy), DW'(exp_ready(m)));
    chk($sformatf("out_valid[b%0d]", m), DW'(o_vld), DW'(mcnt[m] > 0));
    chk($sformatf("occupancy[b%0d]", m), DW'(o_occ), DW'(mcnt[m]));
    if (mcnt[m] > 0) chk($sformatf("out_data[b%0d]", m), o_dat, mq[m][0]);
  endtask

  task automatic model_edge(input int m);
    logic acc, iss;
    acc = IN_VALID && exp_ready(m);
    iss = (mcnt[m] > 0) && OUT_READY && !BUSYWAIT;
    if (RESET || FLUSH) begin
      mcnt[m] = 0;
    end else begin
      if (iss) begin
        for (int k = 0; k < 3; k++) mq[m][k] = mq[m][k+1];
        mcnt[m]--;
      end
      if (acc) begin
        mq[m][mcnt[m]] = IN_DATA;
        mcnt[m]++;
      end
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge CLK);
    model_check(1);
    model_check(0);
    @(posedge CLK);
    model_edge(1);
    model_edge(0);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy);
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = ordy;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; BUSYWAIT = 1'b0;
    drive(1'b1, DW'('hA5), 1'b0);
    mcnt[0] = 0; mcnt[1] = 0;
    @(posedge CLK);
    #1;

    // Reset held with valid input present.
    step();
    step();
    chk("rst_out_data_b1", dat1, '0);
    chk("rst_out_data_b0", dat0, '0);
    chk("rst_in_ready_b1", DW'(rdy1), '0);
    RESET = 1'b0;
    #1;
    chk("post_rst_ready_b1", DW'(rdy1), DW'(1));

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      step();
      chk("stream_data_b1", dat1, DW'(i));
      chk("stream_ready_b1", DW'(rdy1), DW'(1));
    end
    drive(1'b0, '0, 1'b1);
    step();
    step();

    // Backpressure: two entries fill the skid build, the third waits.
    drive(1'b1, DW'('h11), 1'b0);
    step();
    drive(1'b1, DW'('h22), 1'b0);
    step();
    drive(1'b1, DW'('h33), 1'b0);
    #1;
    chk("bp_occ_b1", DW'(occ1), DW'(2));
    chk("bp_ready_b1", DW'(rdy1), DW'(0));
    chk("bp_ready_b0", DW'(rdy0), DW'(0));
    step();
    OUT_READY = 1'b1;
    #1;
    chk("bp_ready_follows_b0", DW'(rdy0), DW'(1));
    step();
    step();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // BUSYWAIT freeze with one entry held.
    drive(1'b1, DW'('h44), 1'b0);
    step();
    BUSYWAIT = 1'b1;
    drive(1'b1, DW'('h99), 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("busy_data_b1", dat1, DW'('h44));
    chk("busy_ready_b1", DW'(rdy1), DW'(0));
    chk("busy_occ_b1", DW'(occ1), DW'(1));
    BUSYWAIT = 1'b0;
    drive(1'b0, '0, 1'b1);
    step();
    chk("busy_release_valid_b1", DW'(vld1), DW'(0));
    step();

    // Flush with two held entries, then again under BUSYWAIT.
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, DW'('h55), 1'b0);
      step();
      drive(1'b1, DW'('h66), 1'b0);
      step();
      chk("flush_pre_occ_b1", DW'(occ1), DW'(2));
      FLUSH = 1'b1;
      BUSYWAIT = (r == 1);
      drive(1'b1, DW'('h77), 1'b0);
      step();
      FLUSH = 1'b0;
      BUSYWAIT = 1'b0;
      drive(1'b0, '0, 1'b1);
      #1;
      chk("flush_valid_b1", DW'(vld1), DW'(0));
      chk("flush_occ_b1", DW'(occ1), DW'(0));
      chk("flush_occ_b0", DW'(occ0), DW'(0));
      step();
      step();
    end

    // Random traffic on both builds against the model.
    for (int c = 0; c < 10000; c++) begin
      RESET     = ($urandom_range(0, 299) == 0);
      FLUSH     = ($urandom_range(0, 39) == 0);
      BUSYWAIT  = ($urandom_range(0, 7) == 0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_DATA   = rnd_data();
      OUT_READY = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
